// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Registered branch resolution stage with a bimodal (2-bit counter) predictor.
//   Resolves the six RISC-V conditional branches one cycle after issue.
//   It computes taken, target and redirect PC, and flags mispredicts against the
//   direction predicted at fetch. Resolved branches train the counter table.
//   Fetch reads the same table through an independent registered lookup port.
//
// Optional feature macro: BRANCH_STATS_EN
//   Adds 32-bit wrapping counters of resolved branches and of mispredicts.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   pred_req_i/pred_pc_i fetch lookup request and PC
//   pred_valid_o         lookup result valid, one cycle after pred_req_i
//   pred_taken_o         predicted direction (counter MSB)
//   res_valid_i          instruction presented for resolution
//   opcode_i, funct3_i   instruction opcode and branch condition
//   rs1_i, rs2_i         compare operands
//   pc_i, imm_i          instruction PC and sign-extended B-immediate
//   pred_taken_i         direction predicted at fetch for this instruction
//   flush_i              drop the current input and mask the in-flight result
//   res_valid_o          resolution result valid
//   breq_o, brlt_o       equality / less-than compare results
//   taken_o              branch condition true
//   target_o             pc + imm
//   redirect_pc_o        taken ? target : pc + 4
//   mispredict_o         taken_o != pred_taken_i (valid branches only)
//   stat_branches_o      (BRANCH_STATS_EN) resolved valid branch count
//   stat_mispredicts_o   (BRANCH_STATS_EN) mispredict count

module branch_resolve_unit #(
  parameter int DWIDTH    = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pred_req_i,
  input  logic [DWIDTH-1:0] pred_pc_i,
  output logic              pred_valid_o,
  output logic              pred_taken_o,
  input  logic              res_valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [DWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] imm_i,
  input  logic              pred_taken_i,
  input  logic              flush_i,
  output logic              res_valid_o,
  output logic              breq_o,
  output logic              brlt_o,
  output logic              taken_o,
  output logic [DWIDTH-1:0] target_o,
  output logic [DWIDTH-1:0] redirect_pc_o,
  output logic              mispredict_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches_o,
  output logic [31:0]       stat_mispredicts_o
`endif
);

  localparam int         IDX_W      = $clog2(BHT_DEPTH);
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [1:0] bht [BHT_DEPTH];

  // ---- stage p0: combinational evaluation of the presented instruction ----
  logic signed [DWIDTH-1:0] rs1_s_p0, rs2_s_p0;
  logic [IDX_W-1:0]  res_idx_p0, pred_idx_p0;
  logic              is_branch_p0, cond_ok_p0, breq_p0, slt_p0, ult_p0;
  logic              cond_p0, taken_p0, accept_p0, train_p0;
  logic [DWIDTH-1:0] target_p0, seq_pc_p0;
  logic              unused_pc_bits;

  assign rs1_s_p0     = $signed(rs1_i);
  assign rs2_s_p0     = $signed(rs2_i);
  assign res_idx_p0   = pc_i[IDX_W+1:2];
  assign pred_idx_p0  = pred_pc_i[IDX_W+1:2];
  assign is_branch_p0 = (opcode_i == OPC_BRANCH);
  // funct3 010/011 are reserved branch encodings
  assign cond_ok_p0   = (funct3_i[2:1] != 2'b01);
  assign breq_p0      = (rs1_i == rs2_i);
  assign slt_p0       = (rs1_s_p0 < rs2_s_p0);
  assign ult_p0       = (rs1_i < rs2_i);
  assign target_p0    = pc_i + imm_i;
  assign seq_pc_p0    = pc_i + DWIDTH'(4);
  assign taken_p0     = is_branch_p0 & cond_ok_p0 & cond_p0;
  assign accept_p0    = res_valid_i & ~flush_i;
  assign train_p0     = accept_p0 & is_branch_p0 & cond_ok_p0;
  assign unused_pc_bits = ^{pred_pc_i[DWIDTH-1:IDX_W+2], pred_pc_i[1:0]};

  always_comb begin
    cond_p0 = 1'b0;
    case (funct3_i)
      3'b000:  cond_p0 = breq_p0;
      3'b001:  cond_p0 = ~breq_p0;
      3'b100:  cond_p0 = slt_p0;
      3'b101:  cond_p0 = ~slt_p0;
      3'b110:  cond_p0 = ult_p0;
      3'b111:  cond_p0 = ~ult_p0;
      default: cond_p0 = 1'b0;
    endcase
  end

  // ---- stage p1: registered results and counter table ----
  logic              vld_p1;
  logic              breq_p1, brlt_p1, taken_p1, mispredict_p1;
  logic [DWIDTH-1:0] target_p1, redirect_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
    end
  end

  // Result data is qualified by vld_p1 at the outputs, so it needs no reset.
  always_ff @(posedge clk_i) begin
    breq_p1       <= is_branch_p0 & breq_p0;
    brlt_p1       <= is_branch_p0 & (funct3_i[1] ? ult_p0 : slt_p0);
    taken_p1      <= taken_p0;
    mispredict_p1 <= is_branch_p0 & cond_ok_p0 & (taken_p0 != pred_taken_i);
    target_p1     <= target_p0;
    redirect_p1   <= taken_p0 ? target_p0 : seq_pc_p0;
  end

  // Lookup reads the pre-update counter when it collides with a training write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
    end else begin
      pred_valid_o <= pred_req_i;
      pred_taken_o <= pred_req_i & bht[pred_idx_p0][1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (train_p0) begin
      bht[res_idx_p0] <= taken_p0 ? sat_inc(bht[res_idx_p0])
                                  : sat_dec(bht[res_idx_p0]);
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_branches_o    <= '0;
      stat_mispredicts_o <= '0;
    end else if (train_p0) begin
      stat_branches_o <= stat_branches_o + 32'd1;
      if (taken_p0 != pred_taken_i) stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
    end
  end
`endif

  // ---- output: flush masks the in-flight result in the same cycle ----
  always_comb begin
    res_valid_o   = vld_p1 & ~flush_i;
    breq_o        = res_valid_o & breq_p1;
    brlt_o        = res_valid_o & brlt_p1;
    taken_o       = res_valid_o & taken_p1;
    mispredict_o  = res_valid_o & mispredict_p1;
    target_o      = res_valid_o ? target_p1 : '0;
    redirect_pc_o = res_valid_o ? redirect_p1 : '0;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        pred_req_i;
  logic [31:0] pred_pc_i;
  logic        pred_valid_o, pred_taken_o;
  logic        res_valid_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i, pc_i, imm_i;
  logic        pred_taken_i, flush_i;
  logic        res_valid_o, breq_o, brlt_o, taken_o, mispredict_o;
  logic [31:0] target_o, redirect_pc_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_o, stat_mispredicts_o;
`endif

  int total = 0;
  int bad   = 0;

  branch_resolve_unit #(.DWIDTH(32), .BHT_DEPTH(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
    .res_valid_i(res_valid_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .pc_i(pc_i), .imm_i(imm_i),
    .pred_taken_i(pred_taken_i), .flush_i(flush_i),
    .res_valid_o(res_valid_o), .breq_o(breq_o), .brlt_o(brlt_o),
    .taken_o(taken_o), .target_o(target_o), .redirect_pc_o(redirect_pc_o),
    .mispredict_o(mispredict_o)
`ifdef BRANCH_STATS_EN
    , .stat_branches_o(stat_branches_o), .stat_mispredicts_o(stat_mispredicts_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] ALU = 7'b0110011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    res_valid_i = 1'b0; pred_req_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pt);
    res_valid_i = 1'b1; opcode_i = op; funct3_i = f3;
    rs1_i = a; rs2_i = b; pc_i = pc; imm_i = imm; pred_taken_i = pt;
  endtask

  task automatic lookup_chk(input string tag, input logic [31:0] pc, input logic exp);
    idle();
    pred_req_i = 1'b1; pred_pc_i = pc;
    tick();
    chk({tag, "_pv"}, 32'(pred_valid_o), 32'd1);
    chk(tag, 32'(pred_taken_o), 32'(exp));
    pred_req_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    pred_pc_i = '0; opcode_i = '0; funct3_i = '0; rs1_i = '0; rs2_i = '0;
    pc_i = '0; imm_i = '0; pred_taken_i = 1'b0;
    tick(); tick();
    chk("rst_res_valid", 32'(res_valid_o), 32'd0);
    chk("rst_pred_valid", 32'(pred_valid_o), 32'd0);
    chk("rst_taken", 32'(taken_o), 32'd0);
    chk("rst_redirect", redirect_pc_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    // Initial lookup: weakly not-taken
    lookup_chk("lk_init", 32'h100, 1'b0);
    chk("lk_init_resv", 32'(res_valid_o), 32'd0);
    chk("lk_init_target", target_o, 32'd0);

    // BEQ taken, predicted not-taken
    issue(BR, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    tick();
    chk("beq_valid", 32'(res_valid_o), 32'd1);
    chk("beq_taken", 32'(taken_o), 32'd1);
    chk("beq_breq", 32'(breq_o), 32'd1);
    chk("beq_target", target_o, 32'h120);
    chk("beq_redirect", redirect_pc_o, 32'h120);
    chk("beq_misp", 32'(mispredict_o), 32'd1);
    chk("beq_nolookup", 32'(pred_valid_o), 32'd0);
    lookup_chk("lk_after_beq", 32'h100, 1'b1);
    chk("idle_zero_target", target_o, 32'd0);

    // BLTU then BLT back-to-back with the same operands
    issue(BR, 3'b110, 32'hFFFF_FFFB, 32'd3, 32'h204, 32'h10, 1'b1);
    tick();
    chk("bltu_valid", 32'(res_valid_o), 32'd1);
    chk("bltu_taken", 32'(taken_o), 32'd0);
    chk("bltu_brlt", 32'(brlt_o), 32'd0);
    chk("bltu_redirect", redirect_pc_o, 32'h208);
    chk("bltu_misp", 32'(mispredict_o), 32'd1);
    issue(BR, 3'b100, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFC, 32'd8, 1'b1);
    tick();
    chk("blt_valid", 32'(res_valid_o), 32'd1);
    chk("blt_taken", 32'(taken_o), 32'd1);
    chk("blt_brlt", 32'(brlt_o), 32'd1);
    chk("blt_target_wrap", target_o, 32'h4);
    chk("blt_redirect", redirect_pc_o, 32'h4);
    chk("blt_misp", 32'(mispredict_o), 32'd0);

    // Four taken BNE back-to-back at 0x40: counter 1 -> 3 (saturated)
    for (int i = 0; i < 4; i++) begin
      issue(BR, 3'b001, 32'd1, 32'd2, 32'h40, 32'h8, 1'b1);
      tick();
      chk("bne_t_valid", 32'(res_valid_o), 32'd1);
      chk("bne_t_taken", 32'(taken_o), 32'd1);
    end
    lookup_chk("lk_sat3", 32'h40, 1'b1);

    // Not-taken BNE: 3 -> 2 -> 1 -> 0 -> 0
    issue(BR, 3'b001, 32'd7, 32'd7, 32'h40, 32'h8, 1'b0);
    tick();
    chk("bne_n_taken", 32'(taken_o), 32'd0);
    chk("bne_n_redirect", redirect_pc_o, 32'h44);
    lookup_chk("lk_cnt2", 32'h40, 1'b1);
    for (int i = 0; i < 3; i++) begin
      issue(BR, 3'b001, 32'd7, 32'd7, 32'h40, 32'h8, 1'b0);
      tick();
      chk("bne_n_valid", 32'(res_valid_o), 32'd1);
      lookup_chk("lk_low", 32'h40, 1'b0);
    end
    // From 0, one taken gives 1 (still not-taken), a second gives 2
    issue(BR, 3'b001, 32'd1, 32'd2, 32'h40, 32'h8, 1'b1);
    tick();
    lookup_chk("lk_sat0_up1", 32'h40, 1'b0);
    issue(BR, 3'b001, 32'd1, 32'd2, 32'h40, 32'h8, 1'b1);
    tick();
    lookup_chk("lk_sat0_up2", 32'h40, 1'b1);

`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches_o, 32'd13);
    chk("stat_misp", stat_mispredicts_o, 32'd2);
`endif

    // Flush with the input: dropped, counter untouched
    issue(BR, 3'b000, 32'd9, 32'd9, 32'h308, 32'h10, 1'b0);
    flush_i = 1'b1;
    tick();
    idle();
    #1;
    chk("flush_in_valid", 32'(res_valid_o), 32'd0);
`ifdef BRANCH_STATS_EN
    chk("flush_stat", stat_branches_o, 32'd13);
`endif
    lookup_chk("lk_flush", 32'h308, 1'b0);

    // Flush one cycle later masks the in-flight result
    issue(BR, 3'b000, 32'd9, 32'd9, 32'h30C, 32'h10, 1'b0);
    tick();
    idle();
    #1;
    chk("inflight_valid", 32'(res_valid_o), 32'd1);
    flush_i = 1'b1;
    #1;
    chk("mask_valid", 32'(res_valid_o), 32'd0);
    chk("mask_taken", 32'(taken_o), 32'd0);
    chk("mask_target", target_o, 32'd0);
    flush_i = 1'b0;
    tick();
    chk("after_mask_valid", 32'(res_valid_o), 32'd0);

    // Same-cycle lookup and taken update at 0x80: pre-update value returned
    issue(BR, 3'b000, 32'd3, 32'd3, 32'h80, 32'h10, 1'b1);
    pred_req_i = 1'b1; pred_pc_i = 32'h80;
    tick();
    chk("same_pred", 32'(pred_taken_o), 32'd0);
    chk("same_taken", 32'(taken_o), 32'd1);
    lookup_chk("lk_same_next", 32'h80, 1'b1);

    // Reserved funct3: no taken, no mispredict, no training
    issue(BR, 3'b010, 32'd4, 32'd4, 32'h410, 32'h20, 1'b1);
    tick();
    chk("inv_valid", 32'(res_valid_o), 32'd1);
    chk("inv_taken", 32'(taken_o), 32'd0);
    chk("inv_misp", 32'(mispredict_o), 32'd0);
    chk("inv_redirect", redirect_pc_o, 32'h414);
    lookup_chk("lk_inv", 32'h410, 1'b0);

    // Non-branch opcode
    issue(ALU, 3'b000, 32'd6, 32'd6, 32'h500, 32'h40, 1'b1);
    tick();
    chk("alu_valid", 32'(res_valid_o), 32'd1);
    chk("alu_breq", 32'(breq_o), 32'd0);
    chk("alu_taken", 32'(taken_o), 32'd0);
    chk("alu_misp", 32'(mispredict_o), 32'd0);
    chk("alu_target", target_o, 32'h540);
    chk("alu_redirect", redirect_pc_o, 32'h504);

    // Reset mid-operation discards the in-flight result and the counters
    issue(BR, 3'b000, 32'd1, 32'd1, 32'h100, 32'h20, 1'b0);
    tick();
    idle();
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 32'(res_valid_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("postrst_valid", 32'(res_valid_o), 32'd0);
`ifdef BRANCH_STATS_EN
    chk("postrst_stat", stat_branches_o, 32'd0);
`endif
    lookup_chk("lk_postrst", 32'h100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
